sclk_arbiter: RTL
=================

# sclk_arbiter

- Shares one `clock_divider` (SPI SCLK generator) between `N_REQ` SPI channel requesters.
- Arbitrates pending requests round-robin, then sequences the divider for the winner:
  - loads the winner's divisor;
  - starts one 8-SCLK burst;
  - waits for the burst to finish;
  - returns a one-cycle done strobe to the winner.
- Sits between the channel front-ends and the divider; it is the only block that drives the divider's configuration and start inputs.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters, legal range 2..4.
- `DIV_W`, 8: divisor width; must match the divider configuration field.

Ports:
- `i_clk`  in  1  system clock, 100 MHz.
- `i_rst`  in  1  reset, asynchronous and active-high.
- `i_req`  in  N_REQ  per-requester level request; sampled only in IDLE.
- `i_divisor`  in  N_REQ*DIV_W  requester k's divisor in bits [k*DIV_W +: DIV_W].
- `o_grant`  out  N_REQ  one-hot; marks the owner of the divider.
- `o_done`  out  N_REQ  one-cycle strobe to the owner when its burst completes.
- `o_busy`  out  1  high in every state except IDLE.
- `o_error`  out  1  one-cycle strobe on watchdog abort; tied 0 without the macro.
- `o_div_config`  out  DIV_W+1  to divider: {divisor, load}.
- `o_div_start_n`  out  1  to divider: start, active-low.
- `i_div_ready`  in  1  from divider: high when the divider is idle.

## Operation
States: IDLE, CONFIG, START, RUN, DONE. All outputs are registered.

- **Reset values:**
  - `o_grant`=0, `o_done`=0, `o_busy`=0, `o_error`=0, `o_div_config`=0, `o_div_start_n`=1.
  - Round-robin pointer=0, so requester 0 has highest priority after reset.
- **IDLE → CONFIG:** taken when `i_req` != 0.
  - Winner is the first set bit searching upward from the pointer, wrapping at N_REQ-1 → 0.
  - Latch the winner index and its divisor.
  - A divisor below 2 is clamped to 2.
- **CONFIG:**
  - Drive `o_grant` one-hot and `o_div_config`={divisor, 1'b1} for exactly one cycle.
  - `o_div_config` returns to 0 on the next cycle.
  - Next state: START.
- **START:** drive `o_div_start_n`=0 until `i_div_ready` is sampled low, then go to RUN.
- **RUN:** `o_div_start_n`=1; wait for `i_div_ready` to be sampled high, then go to DONE.
- **DONE:**
  - `o_done[idx]`=1 for one cycle; `o_grant` is still asserted.
  - Pointer becomes idx+1 mod N_REQ.
  - Next state: IDLE, where `o_grant` returns to 0.
- **Request handling:**
  - Deasserting `i_req` after IDLE does not abort the burst; done is still issued.
  - A requester holding `i_req` through DONE is re-arbitrated normally and may win again if it is the only one pending.
- **Simultaneous requests:** only the winner is served; the others stay pending with no grant.
- **Reset mid-operation:**
  - All outputs return to reset values immediately; no done or error is issued.
  - The divider is reset separately by the system.

## Timing
- Cycle 0: `i_req` sampled in IDLE.
- Cycle 1: CONFIG; `o_grant` and `o_div_config` load pulse.
- Cycle 2: START; `o_div_start_n`=0.
- Burst: about 8×divisor + 3 cycles, depending on divider latency.
- Completion: `o_done` asserts one cycle after `i_div_ready` is sampled high.
- Back-to-back: minimum gap from one DONE to the next CONFIG is 2 cycles (DONE → IDLE → CONFIG).

## Configuration
- **`SCLK_ARB_TIMEOUT_EN` defined:**
  - A 12-bit watchdog counts cycles in START and RUN.
  - It aborts when the count reaches 8×divisor + 32.
  - Abort sets `o_div_start_n`=1, pulses `o_error` and `o_done[idx]` together for one cycle, then goes to IDLE.
  - The pointer advances as on a normal completion.
- **Undefined:** no counter; `o_error` is constant 0; the block waits indefinitely.

## Test plan
- Reset: assert `i_rst` mid-RUN → all outputs at reset values on the same cycle; IDLE after release; no `o_done` pulse.
- Single request: requester 0, divisor 4 → `o_div_config`=9'h009 for 1 cycle; `o_div_start_n` low until ready falls; `o_done[0]` one cycle after ready rises; `o_busy` low 1 cycle later.
- Round robin: `i_req`=2'b11 held, divisors 100 and 2 → grants alternate 0, 1, 0, 1; no grant overlap; each `o_done` goes to the current owner.
- Clamp: divisor 0 → `o_div_config`=9'h005; burst completes normally.
- Request withdrawal: drop `i_req[1]` during RUN → `o_done[1]` still pulses; next grant goes to requester 0 only if it is requesting.
- Watchdog (macro defined): hold `i_div_ready` high (divider stuck), divisor 4 → `o_error` and `o_done` pulse at cycle 2 + 64; `o_div_start_n`=1.

Source files
------------

// File: rtl/sclk_arbiter_if.sv
// Bundles the requester-side and divider-side signals of sclk_arbiter.
// The master modport is the arbiter's view; slave is the view of the logic around it.
interface sclk_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int DIV_W = 8
);
    logic [N_REQ-1:0]       i_req;
    logic [N_REQ*DIV_W-1:0] i_divisor;
    logic [N_REQ-1:0]       o_grant;
    logic [N_REQ-1:0]       o_done;
    logic                   o_busy;
    logic                   o_error;
    logic [DIV_W:0]         o_div_config;
    logic                   o_div_start_n;
    logic                   i_div_ready;

    modport master (
        input  i_req, i_divisor, i_div_ready,
        output o_grant, o_done, o_busy, o_error, o_div_config, o_div_start_n
    );

    modport slave (
        output i_req, i_divisor, i_div_ready,
        input  o_grant, o_done, o_busy, o_error, o_div_config, o_div_start_n
    );
endinterface

// File: rtl/sclk_arbiter.sv
// Round-robin owner of the shared SPI SCLK divider: load divisor, start one burst, return done.
// Define SCLK_ARB_TIMEOUT_EN to add a watchdog that aborts a burst the divider never finishes.
module sclk_arbiter #(
    parameter int N_REQ = 2,
    parameter int DIV_W = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    sclk_arbiter_if.master bus
);
    localparam int IDX_W = (N_REQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {IDLE, CONFIG, START, RUN, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  win_idx;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  win_div;
    logic [N_REQ-1:0]  grant_r;
    logic [N_REQ-1:0]  done_r;
    logic              busy_r;
    logic [DIV_W:0]    cfg_r;
    logic              start_n_r;

    // The divider cannot produce a meaningful SCLK from a divisor of 0 or 1.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_REQ-1:0] v;
        v = '0;
        for (int k = 0; k < N_REQ; k++)
            if (IDX_W'(k) == i) v[k] = 1'b1;
        return v;
    endfunction

    // First pending requester at or above the pointer, wrapping past N_REQ-1.
    always_comb begin
        logic             found;
        int               j;
        logic [IDX_W-1:0] jj;
        logic [DIV_W-1:0] raw;
        found   = 1'b0;
        win_idx = ptr;
        j       = 0;
        jj      = '0;
        raw     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            jj = IDX_W'(j);
            if (!found && bus.i_req[jj]) begin
                found   = 1'b1;
                win_idx = jj;
            end
        end
        for (int k = 0; k < N_REQ; k++)
            if (IDX_W'(k) == win_idx) raw = bus.i_divisor[k*DIV_W +: DIV_W];
        win_div = clamp_div(raw);
    end

    always_ff @(posedge i_clk) begin
        if (state == IDLE && |bus.i_req) begin
            idx   <= win_idx;
            div_q <= win_div;
        end
    end

`ifdef SCLK_ARB_TIMEOUT_EN
    localparam int WD_W = 12;
    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_limit;
    logic            error_r;

    assign wd_limit    = WD_W'({div_q, 3'b000}) + WD_W'(32);
    assign bus.o_error = error_r;
`else
    assign bus.o_error = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_r   <= '0;
            done_r    <= '0;
            busy_r    <= 1'b0;
            cfg_r     <= '0;
            start_n_r <= 1'b1;
`ifdef SCLK_ARB_TIMEOUT_EN
            wd_cnt    <= '0;
            error_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    grant_r   <= '0;
                    done_r    <= '0;
                    busy_r    <= 1'b0;
                    cfg_r     <= '0;
                    start_n_r <= 1'b1;
                    if (|bus.i_req) begin
                        state   <= CONFIG;
                        busy_r  <= 1'b1;
                        grant_r <= onehot(win_idx);
                        cfg_r   <= {win_div, 1'b1};
                    end
                end
                CONFIG: begin
                    cfg_r     <= '0;
                    start_n_r <= 1'b0;
                    state     <= START;
`ifdef SCLK_ARB_TIMEOUT_EN
                    wd_cnt    <= '0;
`endif
                end
                START: begin
                    if (!bus.i_div_ready) begin
                        start_n_r <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (bus.i_div_ready) begin
                        done_r <= onehot(idx);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r    <= '0;
                    grant_r   <= '0;
                    busy_r    <= 1'b0;
                    start_n_r <= 1'b1;
                    ptr       <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
                    state     <= IDLE;
`ifdef SCLK_ARB_TIMEOUT_EN
                    error_r   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
`ifdef SCLK_ARB_TIMEOUT_EN
            // Abort overrides the normal START/RUN transition in the same cycle.
            if (state == START || state == RUN) begin
                if (wd_cnt == wd_limit - WD_W'(1)) begin
                    start_n_r <= 1'b1;
                    done_r    <= onehot(idx);
                    error_r   <= 1'b1;
                    state     <= DONE;
                end else begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
            end
`endif
        end
    end

    assign bus.o_grant       = grant_r;
    assign bus.o_done        = done_r;
    assign bus.o_busy        = busy_r;
    assign bus.o_div_config  = cfg_r;
    assign bus.o_div_start_n = start_n_r;
endmodule
